sseg_mux6_pwm: RTL

//  Six-digit seven-segment multiplexing driver with PWM brightness control.

---
 rtl/sseg_pkg.sv | 38 +++
 rtl/hex_to_sseg.sv | 13 +
 rtl/sseg_mux6_pwm.sv | 120 ++++++++++++
 3 files changed

// File: rtl/sseg_pkg.sv
// Shared constants, digit record and hex-to-segment decode for the
// six-digit multiplexed seven-segment driver.
package sseg_pkg;

  localparam logic [7:0]  SEG_OFF = 8'hFF;
  localparam logic [5:0]  AN_OFF  = 6'h3F;
  localparam int unsigned NDIG    = 6;

  typedef struct packed {
    logic       dp;
    logic [3:0] hex;
  } digit_t;

  // Returns {g,f,e,d,c,b,a}, active-high.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
    logic [6:0] seg;
    unique case (hex)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational {dp, hex} to active-low {dp, g..a} segment byte.
module hex_to_sseg
  import sseg_pkg::*;
(
  input  logic [4:0] digit_i,
  output logic [7:0] seg_o
);

  always_comb begin
    seg_o = ~{digit_i[4], hex_to_seg(digit_i[3:0])};
  end

endmodule

// File: rtl/sseg_mux6_pwm.sv
// Six-digit seven-segment scan driver with per-slot PWM brightness and
// frame-synchronous input snapshot.
module sseg_mux6_pwm
  import sseg_pkg::*;
#(
  parameter int unsigned SUB_DIV = 6250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] in0,
  input  logic [4:0] in1,
  input  logic [4:0] in2,
  input  logic [4:0] in3,
  input  logic [4:0] in4,
  input  logic [4:0] in5,
  input  logic [2:0] bright,
  output logic [5:0] seg_an,
  output logic [7:0] seg_out,
  output logic       frame_start
);

  localparam int unsigned CW      = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam logic [CW-1:0] SUB_MAX = CW'(SUB_DIV - 1);

  logic [CW-1:0] sub_cnt_q, sub_cnt_d;
  logic [2:0]    phase_q, phase_d;
  logic [2:0]    sel_q, sel_d;
  logic [2:0]    bright_sh_q, bright_sh_d;
  logic          load_pending_q;
  digit_t        shadow_q [NDIG];
  digit_t        shadow_d [NDIG];
  digit_t        in_vec   [NDIG];

  logic          sub_wrap, phase_wrap, frame_wrap, snap;
  logic          lit;
  digit_t        cur_digit;
  logic [7:0]    seg_dec;
  logic [5:0]    an_d;
  logic [7:0]    seg_d;

  assign in_vec[0] = digit_t'(in0);
  assign in_vec[1] = digit_t'(in1);
  assign in_vec[2] = digit_t'(in2);
  assign in_vec[3] = digit_t'(in3);
  assign in_vec[4] = digit_t'(in4);
  assign in_vec[5] = digit_t'(in5);

  // Counters hold during the post-reset load cycle so the first slot is full length.
  always_comb begin
    sub_wrap   = (sub_cnt_q == SUB_MAX);
    phase_wrap = sub_wrap && (phase_q == 3'd7);
    frame_wrap = phase_wrap && (sel_q == 3'(NDIG - 1));
    snap       = load_pending_q | frame_wrap;

    sub_cnt_d = sub_cnt_q;
    phase_d   = phase_q;
    sel_d     = sel_q;
    if (!load_pending_q) begin
      sub_cnt_d = sub_wrap ? '0 : sub_cnt_q + 1'b1;
      if (sub_wrap) phase_d = phase_q + 3'd1;
      if (phase_wrap) sel_d = frame_wrap ? '0 : sel_q + 3'd1;
    end
  end

  always_comb begin
    shadow_d    = shadow_q;
    bright_sh_d = bright_sh_q;
    if (snap) begin
      for (int unsigned i = 0; i < NDIG; i++) shadow_d[i] = in_vec[i];
      bright_sh_d = bright;
    end
  end

  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (sel_q == 3'(i)) cur_digit = shadow_q[i];
    end
  end

  hex_to_sseg u_dec (
    .digit_i (cur_digit),
    .seg_o   (seg_dec)
  );

  // Outputs stay dark during the load cycle, then follow sel/phase one cycle late.
  always_comb begin
    lit  = (phase_q <= bright_sh_q) && !load_pending_q;
    an_d = AN_OFF;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (lit && (sel_q == 3'(i))) an_d[i] = 1'b0;
    end
    seg_d = load_pending_q ? SEG_OFF : seg_dec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt_q      <= '0;
      phase_q        <= '0;
      sel_q          <= '0;
      bright_sh_q    <= '0;
      load_pending_q <= 1'b1;
      for (int unsigned i = 0; i < NDIG; i++) shadow_q[i] <= '0;
      seg_an         <= AN_OFF;
      seg_out        <= SEG_OFF;
      frame_start    <= 1'b0;
    end else begin
      sub_cnt_q      <= sub_cnt_d;
      phase_q        <= phase_d;
      sel_q          <= sel_d;
      bright_sh_q    <= bright_sh_d;
      load_pending_q <= 1'b0;
      shadow_q       <= shadow_d;
      seg_an         <= an_d;
      seg_out        <= seg_d;
      frame_start    <= snap;
    end
  end

endmodule
